ofs_fim_emif_axi_credit_gate: RTL and testbench

Credit gate between the AFU memory master and the EMIF AXI-4 memory port. It caps outstanding read beats and outstanding write bursts so EMIF response queues never back up into the AFU. It also provides a quiesce (drain) handshake for partial-reconfiguration and reset sequencing. Data paths pass straight through; only AR/AW valid/ready are gated, and the gate adds zero cycles of latency.

---
 rtl/ofs_fim_mem_if_pkg.sv | 7 +
 rtl/ofs_fim_emif_axi_mm_if.sv | 44 ++++
 rtl/ofs_fim_credit_cnt.sv | 23 ++
 rtl/ofs_fim_emif_axi_credit_gate.sv | 94 +++++++++
 tb/tb_ofs_fim_emif_axi_credit_gate.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ofs_fim_mem_if_pkg.sv
// ofs_fim_mem_if_pkg: shared types and defaults for the EMIF AXI credit gate
package ofs_fim_mem_if_pkg;
  typedef enum logic [1:0] {GATE_RUN, GATE_DRAIN, GATE_IDLE} emif_gate_state_e;
  localparam int EMIF_RD_BEATS_MAX  = 256;
  localparam int EMIF_WR_BURSTS_MAX = 64;
  localparam int EMIF_ARLEN_WIDTH   = 8;
endpackage

// File: rtl/ofs_fim_emif_axi_mm_if.sv
// ofs_fim_emif_axi_mm_if: AXI-4 memory-mapped bundle between AFU and EMIF
interface ofs_fim_emif_axi_mm_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
);
  logic              clk;
  logic              rst_n;
  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast;
  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid, rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  modport emif (
    output clk, rst_n, awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast,
    input  awvalid, awid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
           arvalid, arid, araddr, arlen, arsize, arburst, rready
  );
  modport user (
    input  clk, rst_n, awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast,
    output awvalid, awid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
           arvalid, arid, araddr, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/ofs_fim_credit_cnt.sv
// ofs_fim_credit_cnt: up/down credit counter with net add, zero saturation and underflow pulse
module ofs_fim_credit_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         underflow
);
  logic [W:0] sum;
  always_comb begin
    underflow = dec && cnt == '0;
    sum       = {1'b0, cnt} + {1'b0, inc} - (W+1)'(dec && !underflow);
    cnt_nxt   = sum[W] ? '1 : sum[W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end
endmodule

// File: rtl/ofs_fim_emif_axi_credit_gate.sv
// ofs_fim_emif_axi_credit_gate: caps outstanding EMIF read beats / write bursts and
// provides a drain handshake; only AR/AW valid/ready are gated, everything else passes through.
module ofs_fim_emif_axi_credit_gate
  import ofs_fim_mem_if_pkg::*;
#(
  parameter int RD_BEATS_MAX  = EMIF_RD_BEATS_MAX,
  parameter int WR_BURSTS_MAX = EMIF_WR_BURSTS_MAX,
  parameter int ARLEN_WIDTH   = EMIF_ARLEN_WIDTH,
  localparam int RC_W = $clog2(RD_BEATS_MAX + 1),
  localparam int WC_W = $clog2(WR_BURSTS_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  ofs_fim_emif_axi_mm_if.emif    afu_mem,
  ofs_fim_emif_axi_mm_if.user    emif_mem,
  input  logic                   drain_req,
  output logic                   drained,
  output logic [RC_W-1:0]        rd_cnt,
  output logic [WC_W-1:0]        wr_cnt,
  output logic                   err_underflow
);
  localparam int RN = RC_W + 1;
  if (RD_BEATS_MAX < (1 << ARLEN_WIDTH) || WR_BURSTS_MAX < 1) begin : g_param_err
    $error("credit gate: RD_BEATS_MAX must cover a max burst and WR_BURSTS_MAX must be >= 1");
  end
  emif_gate_state_e state, state_nxt;
  logic            run, rd_ok, wr_ok, ar_hs, aw_hs, r_hs, b_hs, rd_uf, wr_uf;
  logic [RC_W-1:0] rd_inc, rd_nxt;
  logic [WC_W-1:0] wr_nxt;
  always_ff @(posedge clk) begin
    if (rst) state <= GATE_RUN;
    else     state <= state_nxt;
  end
  // DRAIN looks at next-cycle counts so drained rises right after the last retiring response
  always_comb begin
    state_nxt = state == GATE_RUN ? (drain_req ? GATE_DRAIN : GATE_RUN)
              : !drain_req        ? GATE_RUN
              : (rd_nxt == '0 && wr_nxt == '0) ? GATE_IDLE : state;
  end
  always_comb begin
    run     = state == GATE_RUN && !rst;
    drained = state == GATE_IDLE;
  end
  always_comb begin
    rd_ok  = run && ({1'b0, rd_cnt} + RN'(afu_mem.arlen) + RN'(1) <= RN'(RD_BEATS_MAX));
    wr_ok  = run && (wr_cnt < WC_W'(WR_BURSTS_MAX));
    ar_hs  = afu_mem.arvalid && emif_mem.arready && rd_ok;
    aw_hs  = afu_mem.awvalid && emif_mem.awready && wr_ok;
    r_hs   = emif_mem.rvalid && afu_mem.rready;
    b_hs   = emif_mem.bvalid && afu_mem.bready;
    rd_inc = ar_hs ? RC_W'(afu_mem.arlen) + RC_W'(1) : '0;
  end
  ofs_fim_credit_cnt #(.W(RC_W)) u_rd_cnt (
    .clk(clk), .rst(rst), .inc(rd_inc), .dec(r_hs), .cnt(rd_cnt), .cnt_nxt(rd_nxt), .underflow(rd_uf)
  );
  ofs_fim_credit_cnt #(.W(WC_W)) u_wr_cnt (
    .clk(clk), .rst(rst), .inc(WC_W'(aw_hs)), .dec(b_hs), .cnt(wr_cnt), .cnt_nxt(wr_nxt), .underflow(wr_uf)
  );
  always_ff @(posedge clk) begin
    if (rst)                 err_underflow <= 1'b0;
    else if (rd_uf || wr_uf) err_underflow <= 1'b1;
  end
  assign afu_mem.clk      = clk;
  assign afu_mem.rst_n    = ~rst;
  assign emif_mem.arvalid = afu_mem.arvalid && rd_ok;
  assign afu_mem.arready  = emif_mem.arready && rd_ok;
  assign emif_mem.awvalid = afu_mem.awvalid && wr_ok;
  assign afu_mem.awready  = emif_mem.awready && wr_ok;
  assign emif_mem.arid    = afu_mem.arid;
  assign emif_mem.araddr  = afu_mem.araddr;
  assign emif_mem.arlen   = afu_mem.arlen;
  assign emif_mem.arsize  = afu_mem.arsize;
  assign emif_mem.arburst = afu_mem.arburst;
  assign emif_mem.awid    = afu_mem.awid;
  assign emif_mem.awaddr  = afu_mem.awaddr;
  assign emif_mem.awlen   = afu_mem.awlen;
  assign emif_mem.awsize  = afu_mem.awsize;
  assign emif_mem.awburst = afu_mem.awburst;
  assign emif_mem.wvalid  = afu_mem.wvalid;
  assign emif_mem.wdata   = afu_mem.wdata;
  assign emif_mem.wstrb   = afu_mem.wstrb;
  assign emif_mem.wlast   = afu_mem.wlast;
  assign afu_mem.wready   = emif_mem.wready;
  assign afu_mem.bvalid   = emif_mem.bvalid;
  assign afu_mem.bid      = emif_mem.bid;
  assign afu_mem.bresp    = emif_mem.bresp;
  assign emif_mem.bready  = afu_mem.bready;
  assign afu_mem.rvalid   = emif_mem.rvalid;
  assign afu_mem.rid      = emif_mem.rid;
  assign afu_mem.rdata    = emif_mem.rdata;
  assign afu_mem.rresp    = emif_mem.rresp;
  assign afu_mem.rlast    = emif_mem.rlast;
  assign emif_mem.rready  = afu_mem.rready;
endmodule

// File: tb/tb_ofs_fim_emif_axi_credit_gate.sv
// tb_ofs_fim_emif_axi_credit_gate: directed checks of read/write credit limits, drain, underflow and reset
module tb_ofs_fim_emif_axi_credit_gate;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drain_req = 1'b0;
  logic       drained, err_underflow;
  logic [4:0] rd_cnt;
  logic [1:0] wr_cnt;
  int checks = 0;
  int errors = 0;
  ofs_fim_emif_axi_mm_if #(.LEN_W(4)) afu_if ();
  ofs_fim_emif_axi_mm_if #(.LEN_W(4)) emif_if ();
  assign emif_if.clk   = clk;
  assign emif_if.rst_n = ~rst;
  ofs_fim_emif_axi_credit_gate #(.RD_BEATS_MAX(16), .WR_BURSTS_MAX(2), .ARLEN_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .afu_mem(afu_if), .emif_mem(emif_if), .drain_req(drain_req),
    .drained(drained), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    afu_if.arvalid = 0; afu_if.arid = '0; afu_if.araddr = 32'h1000; afu_if.arlen = '0;
    afu_if.arsize = 3'd3; afu_if.arburst = 2'd1;
    afu_if.awvalid = 0; afu_if.awid = '0; afu_if.awaddr = 32'h2000; afu_if.awlen = '0;
    afu_if.awsize = 3'd3; afu_if.awburst = 2'd1;
    afu_if.wvalid = 0; afu_if.wdata = 64'h1234; afu_if.wstrb = '1; afu_if.wlast = 1;
    afu_if.bready = 1; afu_if.rready = 1;
    emif_if.arready = 1; emif_if.awready = 1; emif_if.wready = 1;
    emif_if.bvalid = 0; emif_if.bid = '0; emif_if.bresp = '0;
    emif_if.rvalid = 0; emif_if.rid = '0; emif_if.rdata = '0; emif_if.rresp = '0; emif_if.rlast = 0;
    afu_if.arvalid = 1;
    tick;
    chk("rst_arvalid_gated", emif_if.arvalid, 0);
    chk("rst_n_low", afu_if.rst_n, 0);
    tick;
    afu_if.arvalid = 0;
    rst = 0;
    tick;
    chk("reset_rd_cnt", rd_cnt, 0);
    chk("reset_wr_cnt", wr_cnt, 0);
    chk("reset_drained", drained, 0);
    chk("reset_err", err_underflow, 0);
    chk("rst_n_high", afu_if.rst_n, 1);
    // reads: two 8-beat bursts fill 16 credits exactly
    afu_if.arvalid = 1; afu_if.arlen = 4'd7;
    #1 chk("ar1_ready", afu_if.arready, 1);
    tick;
    chk("rd_cnt_8", rd_cnt, 8);
    chk("ar2_ready_boundary", afu_if.arready, 1);
    tick;
    chk("rd_cnt_16", rd_cnt, 16);
    afu_if.arlen = 4'd0;
    #1 chk("ar3_blocked_ready", afu_if.arready, 0);
    chk("ar3_blocked_valid", emif_if.arvalid, 0);
    tick;
    chk("rd_cnt_held_16", rd_cnt, 16);
    emif_if.rvalid = 1;
    #1 chk("ar3_blocked_during_r", afu_if.arready, 0);
    tick;
    emif_if.rvalid = 0;
    #1 chk("rd_cnt_15", rd_cnt, 15);
    chk("ar3_admitted", afu_if.arready, 1);
    tick;
    afu_if.arvalid = 0;
    chk("rd_cnt_back_16", rd_cnt, 16);
    emif_if.rvalid = 1;
    repeat (11) tick;
    emif_if.rvalid = 0;
    chk("rd_cnt_5", rd_cnt, 5);
    afu_if.arvalid = 1; afu_if.arlen = 4'd3; emif_if.rvalid = 1;
    tick;
    afu_if.arvalid = 0; emif_if.rvalid = 0;
    chk("rd_cnt_net_8", rd_cnt, 8);
    emif_if.rvalid = 1;
    repeat (4) tick;
    emif_if.rvalid = 0;
    chk("rd_cnt_4", rd_cnt, 4);
    // writes: limit of two outstanding bursts, W never gated
    afu_if.awvalid = 1; afu_if.wvalid = 1;
    #1 chk("aw1_ready", afu_if.awready, 1);
    tick;
    chk("wr_cnt_1", wr_cnt, 1);
    tick;
    #1 chk("wr_cnt_2", wr_cnt, 2);
    chk("aw3_blocked_ready", afu_if.awready, 0);
    chk("aw3_blocked_valid", emif_if.awvalid, 0);
    chk("w_pass_valid", emif_if.wvalid, 1);
    chk("w_pass_ready", afu_if.wready, 1);
    chk("w_pass_data", emif_if.wdata[31:0], 32'h1234);
    tick;
    chk("wr_cnt_held_2", wr_cnt, 2);
    emif_if.bvalid = 1;
    tick;
    emif_if.bvalid = 0;
    #1 chk("wr_cnt_after_b", wr_cnt, 1);
    chk("aw3_admitted", afu_if.awready, 1);
    tick;
    afu_if.awvalid = 0;
    chk("wr_cnt_back_2", wr_cnt, 2);
    emif_if.bvalid = 1;
    tick;
    afu_if.awvalid = 1;
    tick;
    afu_if.awvalid = 0; emif_if.bvalid = 0; afu_if.wvalid = 0;
    chk("wr_cnt_net_1", wr_cnt, 1);
    // drain: handshake in the rising cycle still counts, then AR/AW blocked
    drain_req = 1; afu_if.arvalid = 1; afu_if.arlen = 4'd0; afu_if.awvalid = 1;
    #1 chk("drain_edge_ar_ready", afu_if.arready, 1);
    chk("drain_edge_aw_ready", afu_if.awready, 1);
    tick;
    #1 chk("drain_rd_cnt_5", rd_cnt, 5);
    chk("drain_wr_cnt_2", wr_cnt, 2);
    chk("drain_ar_blocked", afu_if.arready, 0);
    chk("drain_aw_blocked", afu_if.awready, 0);
    chk("drain_ar_withdrawn", emif_if.arvalid, 0);
    chk("drain_aw_withdrawn", emif_if.awvalid, 0);
    chk("drain_not_done", drained, 0);
    afu_if.arvalid = 0; afu_if.awvalid = 0;
    emif_if.rvalid = 1; emif_if.bvalid = 1;
    tick;
    tick;
    emif_if.bvalid = 0;
    chk("drain_wr_empty", wr_cnt, 0);
    tick;
    tick;
    chk("drain_rd_1", rd_cnt, 1);
    chk("drain_pending", drained, 0);
    tick;
    emif_if.rvalid = 0;
    #1 chk("drained_one_cycle", drained, 1);
    chk("drained_rd_0", rd_cnt, 0);
    chk("drain_no_err", err_underflow, 0);
    drain_req = 0; afu_if.arvalid = 1; afu_if.arlen = 4'd1;
    #1 chk("idle_ar_blocked", afu_if.arready, 0);
    tick;
    #1 chk("resume_ar_ready", afu_if.arready, 1);
    chk("resume_drained_low", drained, 0);
    tick;
    afu_if.arvalid = 0;
    chk("resume_rd_cnt_2", rd_cnt, 2);
    emif_if.rvalid = 1;
    repeat (2) tick;
    // underflow: one more R beat with an empty counter
    tick;
    emif_if.rvalid = 0;
    chk("uf_rd_cnt_0", rd_cnt, 0);
    chk("uf_err_set", err_underflow, 1);
    tick;
    chk("uf_err_sticky", err_underflow, 1);
    // reset mid-burst
    afu_if.arvalid = 1; afu_if.arlen = 4'd9;
    tick;
    afu_if.arvalid = 0;
    chk("pre_rst_rd_10", rd_cnt, 10);
    rst = 1; afu_if.arvalid = 1;
    #1 chk("rst_mid_arvalid", emif_if.arvalid, 0);
    chk("rst_mid_arready", afu_if.arready, 0);
    chk("rst_mid_rst_n", afu_if.rst_n, 0);
    tick;
    chk("rst_mid_rd_0", rd_cnt, 0);
    chk("rst_mid_wr_0", wr_cnt, 0);
    chk("rst_mid_err_0", err_underflow, 0);
    chk("rst_mid_drained_0", drained, 0);
    rst = 0; afu_if.arvalid = 0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
